// File: rtl/player_link_pkg.sv
// Shared definitions for the player-2 controller link (receiver and future transmitter).
package player_link_pkg;

    localparam logic [2:0] LINK_HEADER = 3'b101;

    localparam int unsigned NUM_BTNS   = 5;
    localparam int unsigned BTN_UP     = 0;
    localparam int unsigned BTN_DOWN   = 1;
    localparam int unsigned BTN_LEFT   = 2;
    localparam int unsigned BTN_RIGHT  = 3;
    localparam int unsigned BTN_ATTACK = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    // One link byte as it appears on the wire after LSB-first reassembly.
    typedef struct packed {
        logic [2:0]          header;
        logic [NUM_BTNS-1:0] btns;
    } link_frame_t;

endpackage

// File: rtl/player_link_rx_if.sv
// Serial input and decoded button levels of the player-2 link receiver.
interface player_link_rx_if;

    logic rx;
    logic up_btn;
    logic down_btn;
    logic left_btn;
    logic right_btn;
    logic attack_btn;
    logic link_up;
    logic frame_err;

    modport slave (
        input  rx,
        output up_btn, down_btn, left_btn, right_btn, attack_btn, link_up, frame_err
    );

    modport master (
        output rx,
        input  up_btn, down_btn, left_btn, right_btn, attack_btn, link_up, frame_err
    );

endinterface

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick: one-cycle pulse every CLK_FREQ/(BAUD*OVERSAMPLE) clocks.
module baud_tick_gen #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    // Divider counter; tick is asserted for the cycle after the terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_W'(TICK_DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/player_link_rx.sv
// 8N1 receiver for the player-2 controller stream with header check and link watchdog.
module player_link_rx #(
    parameter int unsigned CLK_FREQ       = 100_000_000,
    parameter int unsigned BAUD           = 115200,
    parameter int unsigned OVERSAMPLE     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
    input  logic             clk,
    input  logic             reset,
    player_link_rx_if.slave  link
);

    import player_link_pkg::*;

    localparam int unsigned HALF = OVERSAMPLE / 2;
    localparam int unsigned OS_W = $clog2(OVERSAMPLE);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic                rx_meta, rx_sync, rx_prev;
    logic                tick;
    rx_state_e           state_q, state_d;
    logic [OS_W-1:0]     os_cnt_q, os_cnt_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shreg_q, shreg_d;
    link_frame_t         frame_c;
    logic                accept_c, reject_c, wd_expire_c;
    logic [NUM_BTNS-1:0] btns_q;
    logic                link_up_q, frame_err_q;
    logic [WD_W-1:0]     wd_cnt_q;

    baud_tick_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign frame_c     = link_frame_t'(shreg_q);
    assign wd_expire_c = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Two-flop synchronizer plus delayed copy for start-edge detection; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= link.rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    // Next-state logic: mid-bit sampling driven by oversample ticks.
    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        accept_c  = 1'b0;
        reject_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_d  = START;
                    os_cnt_d = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (os_cnt_q == OS_W'(HALF - 1)) begin
                        os_cnt_d  = '0;
                        bit_cnt_d = '0;
                        // A start bit that is high again at mid-bit was only a glitch.
                        state_d   = rx_sync ? IDLE : DATA;
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
                        os_cnt_d  = '0;
                        shreg_d   = {rx_sync, shreg_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
                        os_cnt_d = '0;
                        state_d  = IDLE;
                        if (rx_sync && (frame_c.header == LINK_HEADER)) begin
                            accept_c = 1'b1;
                        end else begin
                            reject_c = 1'b1;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Watchdog: cycles since last accepted frame, saturating at the timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q <= '0;
        end else if (accept_c) begin
            wd_cnt_q <= '0;
        end else if (wd_cnt_q != WD_W'(TIMEOUT_CYCLES)) begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
        end
    end

    // Output registers; an accept on the expiry cycle takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btns_q      <= '0;
            link_up_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= reject_c;
            if (accept_c) begin
                btns_q    <= frame_c.btns;
                link_up_q <= 1'b1;
            end else if (wd_expire_c) begin
                btns_q    <= '0;
                link_up_q <= 1'b0;
            end
        end
    end

    assign link.up_btn     = btns_q[BTN_UP];
    assign link.down_btn   = btns_q[BTN_DOWN];
    assign link.left_btn   = btns_q[BTN_LEFT];
    assign link.right_btn  = btns_q[BTN_RIGHT];
    assign link.attack_btn = btns_q[BTN_ATTACK];
    assign link.link_up    = link_up_q;
    assign link.frame_err  = frame_err_q;

endmodule

// File: tb/tb_player_link_rx.sv
// Scoreboard bench for player_link_rx: frame-level model predicts every visible output event.
module tb_player_link_rx;

    localparam int unsigned CLK_FREQ       = 100_000_000;
    localparam int unsigned BAUD           = 1_562_500;
    localparam int unsigned OVERSAMPLE     = 16;
    localparam int unsigned TIMEOUT_CYCLES = 6000;
    localparam int          BIT_CYC        = int'((CLK_FREQ / (BAUD * OVERSAMPLE)) * OVERSAMPLE);

    typedef struct packed {
        logic       err;
        logic [4:0] btn;
        logic       link;
        logic       tmo;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset;
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    logic   mon_en = 1'b0;
    exp_t   q[$];
    logic [4:0] m_btn;
    logic       m_link;

    player_link_rx_if lnk ();

    player_link_rx #(
        .CLK_FREQ       (CLK_FREQ),
        .BAUD           (BAUD),
        .OVERSAMPLE     (OVERSAMPLE),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .link  (lnk)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic err, input logic [4:0] btn, input logic link, input logic tmo);
        exp_t e;
        e.err  = err;
        e.btn  = btn;
        e.link = link;
        e.tmo  = tmo;
        q.push_back(e);
    endtask

    function automatic logic [4:0] dut_btns();
        return {lnk.attack_btn, lnk.right_btn, lnk.left_btn, lnk.down_btn, lnk.up_btn};
    endfunction

    // Model the frame outcome, then drive start, 8 data bits LSB first, stop, idle gap.
    task automatic send(input logic [7:0] b, input logic stop, input int gap);
        if (stop && (b[7:5] == 3'b101)) begin
            if (!m_link || (m_btn != b[4:0])) push_exp(1'b0, b[4:0], 1'b1, 1'b0);
            m_btn  = b[4:0];
            m_link = 1'b1;
        end else begin
            push_exp(1'b1, m_btn, m_link, 1'b0);
        end
        lnk.rx = 1'b0;
        idle(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            lnk.rx = b[i];
            idle(BIT_CYC);
        end
        lnk.rx = stop;
        idle(BIT_CYC);
        lnk.rx = 1'b1;
        idle(gap);
    endtask

    // Monitor: any frame_err pulse or change of button/link levels is a DUT event.
    initial begin : monitor
        logic [4:0] pb, cb;
        logic       pl, cl, ce;
        longint     last_acc;
        exp_t       e;
        pb = '0;
        pl = 1'b0;
        last_acc = 0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            cb = dut_btns();
            cl = lnk.link_up;
            ce = lnk.frame_err;
            if (ce || (cb != pb) || (cl != pl)) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event got err=%0b btn=%05b link=%0b expected no event", ce, cb, cl);
                end else begin
                    e = q.pop_front();
                    if ({ce, cb, cl} !== {e.err, e.btn, e.link}) begin
                        errors++;
                        $display("FAIL event got err=%0b btn=%05b link=%0b expected err=%0b btn=%05b link=%0b",
                                 ce, cb, cl, e.err, e.btn, e.link);
                    end
                    if (e.tmo) begin
                        checks++;
                        if ((cyc - last_acc) != longint'(TIMEOUT_CYCLES)) begin
                            errors++;
                            $display("FAIL timeout_delay got %0d expected %0d", cyc - last_acc, TIMEOUT_CYCLES);
                        end
                    end
                end
                if (!ce && cl) last_acc = cyc;
            end
            pb = cb;
            pl = cl;
        end
    end

    initial begin : stim
        logic [7:0] b;
        logic       s;
        int         gap;
        int         bad_run;
        logic [7:0] pb8;

        m_btn  = '0;
        m_link = 1'b0;
        lnk.rx = 1'b1;
        reset  = 1'b1;
        idle(5);
        chk("rst_btns_during", 32'(dut_btns()), 32'h0);
        chk("rst_link_during", 32'(lnk.link_up), 32'h0);
        reset = 1'b0;
        idle(3);
        chk("rst_up", 32'(lnk.up_btn), 32'h0);
        chk("rst_down", 32'(lnk.down_btn), 32'h0);
        chk("rst_left", 32'(lnk.left_btn), 32'h0);
        chk("rst_right", 32'(lnk.right_btn), 32'h0);
        chk("rst_attack", 32'(lnk.attack_btn), 32'h0);
        chk("rst_link", 32'(lnk.link_up), 32'h0);
        chk("rst_ferr", 32'(lnk.frame_err), 32'h0);
        mon_en = 1'b1;
        idle(20);

        // Basic decode, header reject, stop-bit reject.
        send(8'hA5, 1'b1, 50);
        send(8'hB0, 1'b1, 50);
        send(8'hA5, 1'b1, 50);
        send(8'h65, 1'b1, 50);
        send(8'hBF, 1'b0, 50);
        send(8'hBF, 1'b1, 50);

        // Short low glitch on an idle line: no event expected.
        lnk.rx = 1'b0;
        idle(12);
        lnk.rx = 1'b1;
        idle(200);
        chk("glitch_btns", 32'(dut_btns()), 32'(m_btn));
        chk("glitch_link", 32'(lnk.link_up), 32'(m_link));

        // Break: one rejected frame, no repeats while the line stays low.
        push_exp(1'b1, m_btn, m_link, 1'b0);
        lnk.rx = 1'b0;
        idle(30 * BIT_CYC);
        lnk.rx = 1'b1;
        idle(100);

        // Randomized frames; invalid runs capped so the watchdog never fires here.
        bad_run = 0;
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom);
            if ($urandom_range(9, 0) < 7) b[7:5] = 3'b101;
            s = ($urandom_range(9, 0) != 0);
            if (bad_run >= 3) begin
                b[7:5] = 3'b101;
                s      = 1'b1;
            end
            if (s && (b[7:5] == 3'b101)) bad_run = 0;
            else bad_run++;
            gap = s ? int'($urandom_range(100, 0)) : int'($urandom_range(100, 20));
            send(b, s, gap);
        end

        // Watchdog: exact expiry after the last accept, then recovery.
        send(8'hA0, 1'b1, 30);
        send(8'hBF, 1'b1, 0);
        push_exp(1'b0, 5'b00000, 1'b0, 1'b1);
        m_btn  = '0;
        m_link = 1'b0;
        idle(int'(TIMEOUT_CYCLES) + 200);
        chk("timeout_link", 32'(lnk.link_up), 32'h0);
        send(8'hA2, 1'b1, 50);

        // Reset during bit 4 of 0xBF discards the partial frame.
        push_exp(1'b0, 5'b00000, 1'b0, 1'b0);
        pb8 = 8'hBF;
        lnk.rx = 1'b0;
        idle(BIT_CYC);
        for (int i = 0; i < 4; i++) begin
            lnk.rx = pb8[i];
            idle(BIT_CYC);
        end
        lnk.rx = pb8[4];
        idle(BIT_CYC / 2);
        reset = 1'b1;
        idle(3);
        lnk.rx = 1'b1;
        reset  = 1'b0;
        m_btn  = '0;
        m_link = 1'b0;
        idle(20 * BIT_CYC);
        chk("midrst_ferr", 32'(lnk.frame_err), 32'h0);
        chk("midrst_btns", 32'(dut_btns()), 32'h0);
        send(8'hA1, 1'b1, 50);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 2000 && q.size() != 0; i++) idle(1);
        chk("queue_empty", 32'(q.size()), 32'h0);
        idle(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
